// File: rtl/encrypt_seq.sv
// encrypt_seq: sequences one encryption job. Each of DIMENSION rows is processed in the same
// way: CHUNKS operand beats are read from memory, the datapath accumulates them, and the result
// is captured and offered on a valid/ready stream. After the last row is accepted, dp_done pulses.
//
// Optional feature: define ENCRYPT_SEQ_ABORT_EN to add the 'abort' input, which cancels a
// running job.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         job request; a rising start seen in IDLE launches one job
//   abort         (ENCRYPT_SEQ_ABORT_EN only) cancel the running job
//   busy          high outside IDLE
//   rd_en/rd_addr operand-memory read strobe and beat address (row*CHUNKS + chunk)
//   dp_en/dp_row  datapath accumulate enable and row, rd_en/row delayed one cycle
//   dp_done       one-cycle job-complete pulse
//   ciphertext    datapath result
//   out_valid/out_ready/out_data  result stream
module encrypt_seq #(
  parameter int unsigned DIMENSION        = 3,
  parameter int unsigned DIM_WIDTH        = 2,
  parameter int unsigned CHUNKS           = 2,
  parameter int unsigned ADDR_WIDTH       = 4,
  parameter int unsigned DP_LATENCY       = 1,
  parameter int unsigned CIPHERTEXT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
`ifdef ENCRYPT_SEQ_ABORT_EN
  input  logic                        abort,
`endif
  output logic                        busy,
  output logic                        rd_en,
  output logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic                        dp_en,
  output logic [DIM_WIDTH-1:0]        dp_row,
  output logic                        dp_done,
  input  logic [CIPHERTEXT_WIDTH-1:0] ciphertext,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CIPHERTEXT_WIDTH-1:0] out_data
);

  localparam int unsigned ChunkW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned WaitW  = (DP_LATENCY > 0) ? $clog2(DP_LATENCY + 1) : 1;

  localparam logic [DIM_WIDTH-1:0] RowLast   = DIM_WIDTH'(DIMENSION - 1);
  localparam logic [ChunkW-1:0]    ChunkLast = ChunkW'(CHUNKS - 1);
  localparam logic [WaitW-1:0]     WaitLast  = WaitW'(DP_LATENCY);

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StOut} state_e;

  state_e                        state_q, state_d;
  logic [DIM_WIDTH-1:0]          row_q, row_d;
  logic [ChunkW-1:0]             chunk_q, chunk_d;
  logic [WaitW-1:0]              wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic                          start_q;
  logic                          dp_en_q;
  logic [DIM_WIDTH-1:0]          dp_row_q;
  logic [CIPHERTEXT_WIDTH-1:0]   out_data_q;
  logic                          capture;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    chunk_d = chunk_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    capture = 1'b0;
    dp_done = 1'b0;
    rd_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Edge-qualified so a start held across a whole job does not reissue.
        if (start && !start_q) begin
          state_d = StFetch;
          row_d   = '0;
          chunk_d = '0;
          addr_d  = '0;
        end
      end
      StFetch: begin
        rd_en = 1'b1;
        if (chunk_q == ChunkLast) begin
          chunk_d = '0;
          wait_d  = '0;
          state_d = StWait;
          // Hold the address on the very last beat so it never wraps.
          if (row_q != RowLast) begin
            addr_d = addr_q + 1'b1;
          end
        end else begin
          chunk_d = chunk_q + 1'b1;
          addr_d  = addr_q + 1'b1;
        end
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          capture = 1'b1;
          state_d = StOut;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StOut: begin
        if (out_ready) begin
          if (row_q == RowLast) begin
            dp_done = 1'b1;
            row_d   = '0;
            addr_d  = '0;
            state_d = StIdle;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef ENCRYPT_SEQ_ABORT_EN
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      row_d   = '0;
      chunk_d = '0;
      addr_d  = '0;
      capture = 1'b0;
      dp_done = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      chunk_q    <= '0;
      wait_q     <= '0;
      addr_q     <= '0;
      start_q    <= 1'b0;
      dp_en_q    <= 1'b0;
      dp_row_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      chunk_q  <= chunk_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      start_q  <= start;
      // One-cycle memory read: the beat reaches the datapath a cycle after the strobe.
      dp_en_q  <= rd_en;
      dp_row_q <= rd_en ? row_q : '0;
      if (capture) begin
        out_data_q <= ciphertext;
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign rd_addr   = rd_en ? addr_q : '0;
  assign dp_en     = dp_en_q;
  assign dp_row    = dp_row_q;
  assign out_valid = (state_q == StOut);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_encrypt_seq.sv
// tb_encrypt_seq: randomized self-checking bench for encrypt_seq (DIMENSION=3, CHUNKS=2,
// DP_LATENCY=1). Stimulus is laid out per cycle in pattern arrays; a schedule model derived
// from the row timing rules turns those patterns into expected outputs per cycle.
module tb_encrypt_seq;

  localparam int D  = 3;
  localparam int C  = 2;
  localparam int L  = 1;
  localparam int W  = 120;

  typedef struct packed {
    logic        busy;
    logic        rd_en;
    logic [3:0]  addr;
    logic        dp_en;
    logic [1:0]  row;
    logic        done;
    logic        valid;
    logic [31:0] data;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic        busy, rd_en, dp_en, dp_done, out_valid;
  logic [3:0]  rd_addr;
  logic [1:0]  dp_row;
  logic [31:0] ciphertext, out_data;
`ifdef ENCRYPT_SEQ_ABORT_EN
  logic        abort;
  logic        abort_pat[W];
`endif

  logic        start_pat[W];
  logic        rdy_pat[W];
  logic        rst_pat[W];
  logic [31:0] ct_pat[W];
  obs_t        exp_q[W];
  logic [31:0] last_od;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  encrypt_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef ENCRYPT_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .dp_en      (dp_en),
    .dp_row     (dp_row),
    .dp_done    (dp_done),
    .ciphertext (ciphertext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  function automatic obs_t sample();
    obs_t o;
    o.busy  = busy;
    o.rd_en = rd_en;
    o.addr  = rd_addr;
    o.dp_en = dp_en;
    o.row   = dp_row;
    o.done  = dp_done;
    o.valid = out_valid;
    o.data  = out_data;
    return o;
  endfunction

  task automatic clear_pats();
    for (int c = 0; c < W; c++) begin
      start_pat[c] = 1'b0;
      rdy_pat[c]   = 1'b1;
      rst_pat[c]   = 1'b0;
      ct_pat[c]    = $urandom;
`ifdef ENCRYPT_SEQ_ABORT_EN
      abort_pat[c] = 1'b0;
`endif
    end
  endtask

  // Expected outputs from the job schedule: row r fetches at f..f+C-1, feeds the datapath
  // one cycle later, captures at f+C+L, offers the result until the first ready cycle h,
  // and the next row fetches from h+1. A reset cycle ends the job and clears out_data.
  task automatic build_model(input logic [31:0] od_init);
    logic        cap_ev[W];
    logic [31:0] cap_val[W];
    logic [31:0] od;
    int          t;
    for (int c = 0; c < W; c++) begin
      exp_q[c]   = '0;
      cap_ev[c]  = 1'b0;
      cap_val[c] = '0;
    end
    t = 0;
    while (t < W) begin
      logic prev;
      prev = (t == 0) ? 1'b0 : (rst_pat[t-1] ? 1'b0 : start_pat[t-1]);
      if (!rst_pat[t] && start_pat[t] && !prev) begin
        int f[D];
        int cap[D];
        int h[D];
        int stop;
        f[0] = t + 1;
        for (int r = 0; r < D; r++) begin
          cap[r] = f[r] + C + L;
          h[r]   = cap[r] + 1;
          while (h[r] < W - 1 && !rdy_pat[h[r]]) h[r]++;
          if (r < D - 1) f[r+1] = h[r] + 1;
        end
        stop = h[D-1];
        for (int c = h[D-1]; c > t; c--) begin
          if (c < W && rst_pat[c]) stop = c;
        end
        for (int r = 0; r < D; r++) begin
          for (int c = f[r]; c <= h[r]; c++) begin
            if (c <= stop && c < W) begin
              exp_q[c].busy = 1'b1;
              if (c < f[r] + C) begin
                exp_q[c].rd_en = 1'b1;
                exp_q[c].addr  = 4'(r * C + c - f[r]);
              end
              if (c > cap[r]) exp_q[c].valid = 1'b1;
              if (c == h[r] && r == D - 1) exp_q[c].done = 1'b1;
            end
          end
          for (int k = 1; k <= C; k++) begin
            if (f[r] + k <= stop && f[r] + k < W) begin
              exp_q[f[r]+k].dp_en = 1'b1;
              exp_q[f[r]+k].row   = 2'(r);
            end
          end
          if (cap[r] < stop && cap[r] + 1 < W) begin
            cap_ev[cap[r]+1]  = 1'b1;
            cap_val[cap[r]+1] = ct_pat[cap[r]];
          end
        end
        t = stop + 1;
      end else begin
        t++;
      end
    end
    for (int c = 0; c < W - 1; c++) begin
      if (rst_pat[c]) begin
        cap_ev[c+1]  = 1'b1;
        cap_val[c+1] = '0;
      end
    end
    od = od_init;
    for (int c = 0; c < W; c++) begin
      if (cap_ev[c]) od = cap_val[c];
      exp_q[c].data = od;
    end
  endtask

  // Drives cycle c's inputs (just after the rising edge) and waits to the falling edge.
  task automatic apply_cycle(input int c);
    rst        = rst_pat[c];
    start      = start_pat[c];
    out_ready  = rdy_pat[c];
    ciphertext = ct_pat[c];
`ifdef ENCRYPT_SEQ_ABORT_EN
    abort      = abort_pat[c];
`endif
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    clear_pats();
    for (int c = 0; c < 4; c++) begin
      rst_pat[c]   = 1'b1;
      start_pat[c] = 1'b1;
    end
    build_model(32'd0);
    for (int c = 0; c < 12; c++) begin
      apply_cycle(c);
      got = sample();
      n_cmp++;
      if (got !== exp_q[c]) begin
        n_bad++;
        $display("FAIL reset cycle %0d: got %h expected %h", c, got, exp_q[c]);
      end
      n_cmp++;
      if (got !== obs_t'(0)) begin
        n_bad++;
        $display("FAIL reset_values cycle %0d: got %h expected all zero", c, got);
      end
      next_cycle();
    end
    last_od = exp_q[11].data;
  endtask

  task automatic test_single_job();
    obs_t got;
    clear_pats();
    start_pat[0] = 1'b1;
    for (int c = 0; c < W; c++) ct_pat[c] = (c <= 6) ? 32'd55 : (c <= 11) ? 32'd22 : 32'd9;
    build_model(last_od);
    for (int c = 0; c < 30; c++) begin
      apply_cycle(c);
      got = sample();
      n_cmp++;
      if (got !== exp_q[c]) begin
        n_bad++;
        $display("FAIL single_job cycle %0d: got %h expected %h", c, got, exp_q[c]);
      end
      if (c == 1 || c == 2 || c == 6) begin
        n_cmp++;
        if (got.rd_en !== 1'b1 || got.addr !== ((c == 6) ? 4'd2 : 4'(c - 1))) begin
          n_bad++;
          $display("FAIL first_fetch cycle %0d: rd_en %b addr %0d", c, got.rd_en, got.addr);
        end
      end
      if (c == 5 || c == 10 || c == 15) begin
        n_cmp++;
        if (got.valid !== 1'b1 ||
            got.data !== ((c == 5) ? 32'd55 : (c == 10) ? 32'd22 : 32'd9)) begin
          n_bad++;
          $display("FAIL result_seq cycle %0d: valid %b data %0d", c, got.valid, got.data);
        end
      end
      if (c == 15 || c == 16) begin
        n_cmp++;
        if (got.done !== (c == 15) || got.busy !== (c == 15)) begin
          n_bad++;
          $display("FAIL job_end cycle %0d: done %b busy %b", c, got.done, got.busy);
        end
      end
      next_cycle();
    end
    last_od = exp_q[29].data;
  endtask

  task automatic test_stall();
    obs_t got;
    int   n_valid;
    int   n_rd;
    clear_pats();
    start_pat[0] = 1'b1;
    for (int c = 10; c <= 13; c++) rdy_pat[c] = 1'b0;
    build_model(last_od);
    n_valid = 0;
    n_rd    = 0;
    for (int c = 0; c < 30; c++) begin
      apply_cycle(c);
      got = sample();
      n_cmp++;
      if (got !== exp_q[c]) begin
        n_bad++;
        $display("FAIL stall cycle %0d: got %h expected %h", c, got, exp_q[c]);
      end
      if (c >= 10 && c <= 14) begin
        n_valid += int'(got.valid);
        n_rd    += int'(got.rd_en);
        n_cmp++;
        if (got.data !== ct_pat[9]) begin
          n_bad++;
          $display("FAIL stall_data cycle %0d: got %h expected %h", c, got.data, ct_pat[9]);
        end
      end
      next_cycle();
    end
    n_cmp++;
    if (n_valid != 5 || n_rd != 0) begin
      n_bad++;
      $display("FAIL stall_hold: valid cycles %0d (want 5), rd_en cycles %0d (want 0)",
               n_valid, n_rd);
    end
    last_od = exp_q[29].data;
  endtask

  task automatic test_reset_mid();
    obs_t got;
    clear_pats();
    start_pat[0]  = 1'b1;
    rst_pat[7]    = 1'b1;
    start_pat[10] = 1'b1;
    build_model(last_od);
    for (int c = 0; c < 40; c++) begin
      apply_cycle(c);
      got = sample();
      n_cmp++;
      if (got !== exp_q[c]) begin
        n_bad++;
        $display("FAIL reset_mid cycle %0d: got %h expected %h", c, got, exp_q[c]);
      end
      if (c == 8) begin
        n_cmp++;
        if (got !== obs_t'(0)) begin
          n_bad++;
          $display("FAIL reset_mid_values: got %h expected all zero", got);
        end
      end
      if (c == 11) begin
        n_cmp++;
        if (got.rd_en !== 1'b1 || got.addr !== 4'd0) begin
          n_bad++;
          $display("FAIL restart_addr: rd_en %b addr %0d expected 1 / 0", got.rd_en, got.addr);
        end
      end
      next_cycle();
    end
    last_od = exp_q[39].data;
  endtask

  task automatic test_start_held();
    obs_t got;
    int   n_rd;
    int   n_done;
    clear_pats();
    for (int c = 0; c <= 30; c++) start_pat[c] = 1'b1;
    build_model(last_od);
    n_rd   = 0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      apply_cycle(c);
      got = sample();
      n_rd   += int'(got.rd_en);
      n_done += int'(got.done);
      n_cmp++;
      if (got !== exp_q[c]) begin
        n_bad++;
        $display("FAIL start_held cycle %0d: got %h expected %h", c, got, exp_q[c]);
      end
      next_cycle();
    end
    n_cmp++;
    if (n_rd != D * C || n_done != 1) begin
      n_bad++;
      $display("FAIL single_issue: rd_en beats %0d (want %0d), dp_done pulses %0d (want 1)",
               n_rd, D * C, n_done);
    end
    last_od = exp_q[39].data;
  endtask

  task automatic test_random_jobs();
    obs_t got;
    for (int it = 0; it < 5; it++) begin
      clear_pats();
      for (int c = 0; c < 80; c++) begin
        start_pat[c] = ($urandom_range(0, 9) == 0);
        rdy_pat[c]   = ($urandom_range(0, 9) < 7);
        rst_pat[c]   = ($urandom_range(0, 99) < 2);
      end
      build_model(last_od);
      for (int c = 0; c < W; c++) begin
        apply_cycle(c);
        got = sample();
        n_cmp++;
        if (got !== exp_q[c]) begin
          n_bad++;
          $display("FAIL random_%0d cycle %0d: got %h expected %h", it, c, got, exp_q[c]);
        end
        next_cycle();
      end
      last_od = exp_q[W-1].data;
    end
  endtask

`ifdef ENCRYPT_SEQ_ABORT_EN
  task automatic test_abort();
    obs_t got;
    int   n_done;
    clear_pats();
    start_pat[0]  = 1'b1;
    abort_pat[13] = 1'b1;
    abort_pat[25] = 1'b1;
    build_model(last_od);
    // Row 2 is in its first wait cycle at 13; the job ends there.
    exp_q[13].done = 1'b1;
    for (int c = 14; c < 40; c++) begin
      exp_q[c]      = '0;
      exp_q[c].data = exp_q[13].data;
    end
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      apply_cycle(c);
      got = sample();
      n_done += int'(got.done);
      n_cmp++;
      if (got !== exp_q[c]) begin
        n_bad++;
        $display("FAIL abort cycle %0d: got %h expected %h", c, got, exp_q[c]);
      end
      next_cycle();
    end
    n_cmp++;
    if (n_done != 1) begin
      n_bad++;
      $display("FAIL abort_done: dp_done pulses %0d expected 1", n_done);
    end
    last_od = exp_q[39].data;
  endtask
`endif

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
`ifdef ENCRYPT_SEQ_ABORT_EN
    abort      = 1'b0;
`endif
    last_od    = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_job();
    test_stall();
    test_reset_mid();
    test_start_held();
    test_random_jobs();
`ifdef ENCRYPT_SEQ_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encrypt_seq.md
ENCRYPT_SEQ -- requirements
Module: encrypt_seq

Interface
REQ-001 SHALL have parameter DIMENSION, default 3, rows per job (ciphertext words produced).
REQ-002 SHALL have parameter DIM_WIDTH, default 2, width of row index; 2^DIM_WIDTH >= DIMENSION.
REQ-003 SHALL have parameter CHUNKS, default 2, operand beats per row (BIG_N/PARALLEL, rounded up), >= 1.
REQ-004 SHALL have parameter ADDR_WIDTH, default 4, operand-memory address width; 2^ADDR_WIDTH >= DIMENSION*CHUNKS.
REQ-005 SHALL have parameter DP_LATENCY, default 1, cycles from last dp_en beat to valid ciphertext, >= 0.
REQ-006 SHALL have parameter CIPHERTEXT_WIDTH, default 32.
REQ-007 SHALL have port clk  in  1  sole clock, all logic rising-edge.
REQ-008 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-009 SHALL have port start  in  1  job request, sampled only in IDLE.
REQ-010 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-011 SHALL have port rd_en  out  1  operand-memory read strobe (op1/op2 lanes, one beat).
REQ-012 SHALL have port rd_addr  out  ADDR_WIDTH  operand beat address = row*CHUNKS + chunk.
REQ-013 SHALL have port dp_en  out  1  datapath accumulate enable (one beat of op1/op2 valid).
REQ-014 SHALL have port dp_row  out  DIM_WIDTH  row index presented to the datapath.
REQ-015 SHALL have port dp_done  out  1  one-cycle job-complete pulse to the datapath.
REQ-016 SHALL have port ciphertext  in  CIPHERTEXT_WIDTH  datapath result.
REQ-017 SHALL have port out_valid / out_ready / out_data  out/in/out  1/1/CIPHERTEXT_WIDTH  result stream.

Function
REQ-018 SHALL implement FSM IDLE -> FETCH -> WAIT -> OUT -> (FETCH for next row | IDLE after last row).
REQ-019 IDLE: start=1 SHALL move to FETCH next cycle with row=0, chunk=0, rd_addr=0.
REQ-020 FETCH SHALL last exactly CHUNKS cycles, rd_en=1 each cycle, rd_addr incrementing by 1 per cycle.
REQ-021 dp_en and dp_row SHALL be rd_en and current row delayed by exactly one cycle (1-cycle memory read).
REQ-022 WAIT SHALL last DP_LATENCY+1 cycles; in its final cycle ciphertext SHALL be captured into out_data.
REQ-023 OUT SHALL hold out_valid=1 and out_data stable until out_valid & out_ready; no further rd_en while in OUT.
REQ-024 On handshake in OUT: if row < DIMENSION-1, row increments and FSM enters FETCH next cycle; else FSM enters IDLE and dp_done pulses for that one cycle.
REQ-025 rd_addr SHALL continue from the previous row (no gap); counters SHALL never wrap within a job.
REQ-026 out_ready=1 in the capture cycle SHALL have no effect; handshake only counts while out_valid=1.
REQ-027 start asserted while busy SHALL be ignored (not queued).
REQ-028 Latency per row SHALL be CHUNKS + DP_LATENCY + 2 cycles with out_ready held high.

Reset
REQ-029 rst=1 SHALL force IDLE at the next edge from any state, including mid-FETCH/OUT, discarding the job.
REQ-030 Reset values: busy=0, rd_en=0, rd_addr=0, dp_en=0, dp_row=0, dp_done=0, out_valid=0, out_data=0.
REQ-031 rst SHALL take priority over start and abort in the same cycle.

Configuration
REQ-032 Macro ENCRYPT_SEQ_ABORT_EN SHALL, when defined, add port abort  in  1.
REQ-033 With ENCRYPT_SEQ_ABORT_EN: abort=1 in any non-IDLE state SHALL return to IDLE next cycle, drop out_valid, pulse dp_done once; abort in IDLE ignored.
REQ-034 Without ENCRYPT_SEQ_ABORT_EN: no abort port; jobs run to completion unless rst.

Verification (DIMENSION=3, CHUNKS=2, DP_LATENCY=1)
REQ-035 Start at cycle 0, out_ready=1 -> rd_en cycles 1-2 addr 0,1; dp_en cycles 2-3 row 0; out_valid cycle 5; next rd_en cycle 6 addr 2.
REQ-036 Full job with datapath returning 55, 22, 9 -> out_data sequence 55, 22, 9; dp_done single pulse on third handshake cycle; busy low after.
REQ-037 out_ready low 4 cycles on row 1 -> out_valid held 5 cycles, out_data=22 stable, no rd_en during stall.
REQ-038 rst pulsed mid-FETCH of row 1 -> all outputs at reset values next cycle; new start restarts at rd_addr 0.
REQ-039 start held high through a job -> exactly one job per rising start-in-IDLE; no back-to-back double issue.
REQ-040 ENCRYPT_SEQ_ABORT_EN defined, abort in WAIT of row 2 -> IDLE next cycle, out_valid=0, one dp_done pulse.
